// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer
//   Hazard and sequencing controller for an NSTAGES-deep in-order pipeline.
//   Turns per-stage stall/flush requests into register enables and bubble
//   strobes, and runs an interrupt drain sequence (IDLE -> DRAIN -> FLUSH)
//   that stops fetch, lets older work retire, flushes, then acknowledges.
//
//   Parameters: NSTAGES (3..8), DRAIN_MAX (>= NSTAGES-1), CNT_W.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     stall_req[N]        stage j cannot advance this cycle
//     flush_req[N]        redirect resolved in stage i, younger work discarded
//     irq_req             level interrupt request
//     inflight_busy       outstanding long-latency op blocks the final flush
//     stage_en[N]         bit 0 PC enable, bit k register feeding stage k
//     stage_clr[N]        bubble load for register feeding stage k (bit 0 = 0)
//     irq_ack             one-cycle pulse: pipeline flushed, trap PC may load
//     drain_timeout       with irq_ack when the drain ended by timeout
//   Optional (macro PIPE_CTRL_PERF_EN):
//     perf_clr            synchronous counter clear
//     perf_stall_cnt / perf_flush_cnt / perf_irq_cnt   saturating counters
module pipeline_hazard_sequencer #(
  parameter int unsigned NSTAGES   = 5,
  parameter int unsigned DRAIN_MAX = 15,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NSTAGES-1:0] stall_req,
  input  logic [NSTAGES-1:0] flush_req,
  input  logic               irq_req,
  input  logic               inflight_busy,
  output logic [NSTAGES-1:0] stage_en,
  output logic [NSTAGES-1:0] stage_clr,
  output logic               irq_ack,
  output logic               drain_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic               perf_clr,
  output logic [CNT_W-1:0]   perf_stall_cnt,
  output logic [CNT_W-1:0]   perf_flush_cnt,
  output logic [CNT_W-1:0]   perf_irq_cnt
`endif
);

  localparam int unsigned TW = $clog2(DRAIN_MAX + 1);
  localparam logic [TW-1:0] ADV_TGT = TW'(NSTAGES - 1);
  localparam logic [TW-1:0] TOT_MAX = TW'(DRAIN_MAX);

  if (NSTAGES < 3 || NSTAGES > 8 || DRAIN_MAX < NSTAGES - 1 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_hazard_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] adv_q, adv_d, adv_inc;
  logic [TW-1:0] tot_q, tot_d;
  logic          to_q, to_d;

  logic               stall_v, flush_v;
  logic [31:0]        js, fi;
  logic [NSTAGES-1:0] base_en, base_clr;

  // Stall/flush resolution. An older stall (js > fi) beats the flush entirely;
  // otherwise the flush re-enables every stage up to fi and bubbles 1..fi,
  // which also covers the bubble a younger stall would have inserted.
  always_comb begin
    stall_v  = 1'b0;
    flush_v  = 1'b0;
    js       = '0;
    fi       = '0;
    base_en  = '1;
    base_clr = '0;
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      if (stall_req[k]) begin
        stall_v = 1'b1;
        js      = k;
      end
      if (flush_req[k]) begin
        flush_v = 1'b1;
        fi      = k;
      end
    end
    if (stall_v && !(flush_v && fi >= js)) begin
      for (int unsigned k = 0; k < NSTAGES; k++) begin
        if (k <= js) base_en[k] = 1'b0;
        if (k == js + 32'd1) base_clr[k] = 1'b1;
      end
    end else if (flush_v) begin
      for (int unsigned k = 1; k < NSTAGES; k++) begin
        if (k <= fi) base_clr[k] = 1'b1;
      end
    end
  end

  always_comb begin
    stage_en  = base_en;
    stage_clr = base_clr;
    case (state_q)
      DRAIN: begin
        stage_en[0]  = 1'b0;
        stage_clr[1] = 1'b1;
      end
      FLUSH: begin
        stage_en     = '1;
        stage_clr    = '1;
        stage_clr[0] = 1'b0;
      end
      default: ;
    endcase
  end

  // Exit test uses the post-increment advance count so the current cycle's
  // advance counts; the timeout compares the registered total.
  always_comb begin
    state_d = state_q;
    adv_d   = adv_q;
    tot_d   = tot_q;
    to_d    = to_q;
    adv_inc = (stall_req == '0 && adv_q != '1) ? adv_q + 1'b1 : adv_q;
    case (state_q)
      IDLE: begin
        if (irq_req) begin
          state_d = DRAIN;
          adv_d   = '0;
          tot_d   = '0;
          to_d    = 1'b0;
        end
      end
      DRAIN: begin
        adv_d = adv_inc;
        tot_d = (tot_q != '1) ? tot_q + 1'b1 : tot_q;
        if (adv_inc >= ADV_TGT && !inflight_busy) begin
          state_d = FLUSH;
        end else if (tot_q == TOT_MAX) begin
          state_d = FLUSH;
          to_d    = 1'b1;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      adv_q   <= '0;
      tot_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      adv_q   <= adv_d;
      tot_q   <= tot_d;
      to_q    <= to_d;
    end
  end

  assign irq_ack       = (state_q == FLUSH);
  assign drain_timeout = (state_q == FLUSH) && to_q;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_irq_cnt   <= '0;
    end else if (perf_clr) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_irq_cnt   <= '0;
    end else begin
      if (|stall_req && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (|flush_req && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (irq_ack && perf_irq_cnt != '1)      perf_irq_cnt   <= perf_irq_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
module tb_pipeline_hazard_sequencer;
  localparam int N    = 5;
  localparam int DMAX = 15;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] stall_req, flush_req;
  logic         irq_req, inflight_busy;
  logic [N-1:0] stage_en, stage_clr;
  logic         irq_ack, drain_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic         perf_clr;
  logic [31:0]  perf_stall_cnt, perf_flush_cnt, perf_irq_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(.NSTAGES(N), .DRAIN_MAX(DMAX), .CNT_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .irq_req       (irq_req),
    .inflight_busy (inflight_busy),
    .stage_en      (stage_en),
    .stage_clr     (stage_clr),
    .irq_ack       (irq_ack),
    .drain_timeout (drain_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_irq_cnt   (perf_irq_cnt)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: interrupt handling tracked as "draining for m_elapsed
  // cycles with m_adv advances", plus a pending acknowledge cycle.
  bit m_drain = 0, m_ack = 0, m_to = 0;
  int m_elapsed = 0, m_adv = 0;

  function automatic logic [2*N-1:0] exp_stage(input logic [N-1:0] st, input logic [N-1:0] fl,
                                                input bit drn, input bit ack);
    logic [N-1:0] en, clr;
    int js, fi;
    js = -1;
    fi = -1;
    for (int k = 0; k < N; k++) begin
      if (st[k]) js = k;
      if (fl[k]) fi = k;
    end
    en  = '1;
    clr = '0;
    if (ack) begin
      clr    = '1;
      clr[0] = 1'b0;
    end else begin
      if (js >= 0 && js > fi) begin
        for (int k = 0; k <= js; k++) en[k] = 1'b0;
        if (js < N - 1) clr[js+1] = 1'b1;
      end else begin
        for (int k = 1; k <= fi; k++) clr[k] = 1'b1;
      end
      if (drn) begin
        en[0]  = 1'b0;
        clr[1] = 1'b1;
      end
    end
    return {en, clr};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_drain = 0; m_ack = 0; m_to = 0; m_elapsed = 0; m_adv = 0;
    end else if (m_ack) begin
      m_ack = 0;
    end else if (m_drain) begin
      if (stall_req == 0) m_adv++;
      if (m_adv >= N - 1 && !inflight_busy) begin
        m_drain = 0; m_ack = 1; m_to = 0;
      end else if (m_elapsed == DMAX) begin
        m_drain = 0; m_ack = 1; m_to = 1;
      end
      m_elapsed++;
    end else if (irq_req) begin
      m_drain = 1; m_elapsed = 0; m_adv = 0;
    end
  end

  always @(negedge clk) begin
    logic [2*N-1:0] e;
    if (reset_n === 1'b1) begin
      e = exp_stage(stall_req, flush_req, m_drain, m_ack);
      chk("stage_en",      stage_en,      e[2*N-1:N]);
      chk("stage_clr",     stage_clr,     e[N-1:0]);
      chk("irq_ack",       irq_ack,       m_ack);
      chk("drain_timeout", drain_timeout, m_ack && m_to);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic irq_latency(output int lat, output logic to_seen);
    lat     = 0;
    to_seen = 1'b0;
    irq_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      next();
      irq_req = 1'b0;
      if (irq_ack) begin
        lat     = c;
        to_seen = drain_timeout;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic to_seen;
    logic seen;
    reset_n = 1'b0;
    stall_req = '0; flush_req = '0; irq_req = 1'b0; inflight_busy = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int c = 0; c < 3; c++) begin
      #2;
      chk("reset_en",  stage_en,  5'b11111);
      chk("reset_clr", stage_clr, 5'b00000);
      chk("reset_ack", irq_ack,   1'b0);
      next();
    end

    stall_req = 5'b00100;
    #2;
    chk("stall2_en",  stage_en,  5'b11000);
    chk("stall2_clr", stage_clr, 5'b01000);
    next();
    flush_req = 5'b10000;
    #2;
    chk("flush4_en",  stage_en,  5'b11111);
    chk("flush4_clr", stage_clr, 5'b11110);
    next();

    stall_req = 5'b01000; flush_req = 5'b00100;
    #2;
    chk("oldstall_en",  stage_en,  5'b10000);
    chk("oldstall_clr", stage_clr, 5'b10000);
    next();
    stall_req = '0; flush_req = '0;
    next();

    irq_latency(lat, to_seen);
    chk("irq_latency_min", lat, 5);
    chk("irq_timeout_min", to_seen, 1'b0);
    next();

    inflight_busy = 1'b1;
    irq_latency(lat, to_seen);
    chk("irq_latency_max", lat, 17);
    chk("irq_timeout_max", to_seen, 1'b1);
    inflight_busy = 1'b0;
    next();
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_irq_two", perf_irq_cnt, 2);
`endif

    irq_req = 1'b1;
    next();
    irq_req = 1'b0;
    next();
    next();
    reset_n = 1'b0;
    next();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (irq_ack) seen = 1'b1;
      next();
    end
    chk("abort_no_ack", seen, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_irq_after_reset", perf_irq_cnt, 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        stall_req[k] = ($urandom_range(0, 9) == 0);
        flush_req[k] = ($urandom_range(0, 11) == 0);
      end
      irq_req       = ($urandom_range(0, 5) == 0);
      inflight_busy = ($urandom_range(0, 2) == 0);
`ifdef PIPE_CTRL_PERF_EN
      perf_clr = ($urandom_range(0, 49) == 0);
`endif
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_sequencer.md
# pipeline_hazard_sequencer

Parametrised hazard and sequencing controller for an N-stage in-order core pipeline. It generates per-stage register enables and bubble/clear strobes from per-stage stall and flush requests. It adds a registered interrupt-drain state machine that freezes fetch, lets older instructions retire, flushes, then acknowledges. It sits beside the datapath pipeline registers in the core controllers and replaces fixed-stage hazard wiring.

## Interface
- NSTAGES, 5, number of pipeline stages. Stage 0 is the PC/fetch stage (youngest); stage NSTAGES-1 is writeback (oldest). Legal range is 3..8.
- DRAIN_MAX, 15, drain timeout in cycles. Must satisfy DRAIN_MAX >= NSTAGES-1.
- CNT_W, 32, width of the performance counters.
- clk  in  1  core clock.
- reset_n  in  1  reset, asynchronous and active-low.
- stall_req  in  NSTAGES  bit j: the instruction in stage j cannot leave this cycle.
- flush_req  in  NSTAGES  bit i: redirect resolved in stage i; all younger work is discarded.
- irq_req  in  1  level interrupt request.
- inflight_busy  in  1  an outstanding memory or divide operation must complete before the flush.
- stage_en  out  NSTAGES  bit 0 is the PC enable; bit k>0 is the enable of the register feeding stage k.
- stage_clr  out  NSTAGES  bit k>0 loads a bubble into the register feeding stage k; bit 0 is always 0.
- irq_ack  out  1  one-cycle pulse; the pipeline is flushed and the trap PC may load.
- drain_timeout  out  1  one-cycle pulse, coincident with irq_ack, when the drain ended by timeout.
- perf_clr  in  1  synchronous clear of the counters (present only with the macro).
- perf_stall_cnt, perf_flush_cnt, perf_irq_cnt  out  CNT_W each  performance counters (present only with the macro).

## Operation
- **Stall rule.** Let js be the highest index with stall_req[js] set.
  - stage_en[k]=0 for all k<=js.
  - If js<NSTAGES-1, stage_clr[js+1]=1, so a bubble is inserted behind the stalled instruction.
- **Flush rule.** Let i be the highest index with flush_req[i] set (oldest flush wins).
  - stage_clr[k]=1 for 1<=k<=i.
  - stage_en[k]=1 for k<=i, overriding stall from stages <=i. This includes stage_en[0]=1 so the redirect PC loads.
  - A stall in a stage older than i (js>i) overrides the flush: all enables for k<=js are 0 and no clears are issued at or below js. The flush must be re-asserted by its source.
- **FSM states:** IDLE, DRAIN, FLUSH.
- **IDLE.** Pure stall/flush rules apply. If irq_req=1, the next state is DRAIN, and adv_cnt and tot_cnt are cleared.
- **DRAIN.**
  - stage_en[0]=0 and stage_clr[1]=1, so no new fetch enters. Older stages follow the stall/flush rules.
  - A flush_req during DRAIN is honoured, but stage_en[0] stays 0.
  - tot_cnt increments every cycle. adv_cnt increments on cycles where stall_req==0.
  - Exit to FLUSH when adv_cnt>=NSTAGES-1 and inflight_busy=0.
  - Otherwise exit to FLUSH when tot_cnt==DRAIN_MAX, and set the timeout flag.
  - Deasserting irq_req during DRAIN does not abort the drain.
- **FLUSH** (one cycle).
  - stage_clr[k]=1 for all k>=1 and stage_en all 1.
  - irq_ack=1, and drain_timeout equals the timeout flag.
  - Next state is IDLE. A still-asserted irq_req is re-sampled only from IDLE.
- Counters saturate at their maximum width. tot_cnt is $clog2(DRAIN_MAX+1) bits wide.

## Timing
- stage_en and stage_clr are combinational from the inputs and the registered state, with zero-cycle latency.
- FSM state, counters and the timeout flag are registered.
- irq_ack and drain_timeout are decoded from the registered state only, so they are glitch-free.
- Minimum irq_req-to-irq_ack latency is NSTAGES cycles (1 cycle into DRAIN, NSTAGES-1 advancing cycles, then FLUSH). Maximum latency is DRAIN_MAX+2 cycles.
- **Reset values:**
  - FSM in IDLE; all counters and the timeout flag at 0.
  - With all inputs low: stage_en all 1, stage_clr all 0, irq_ack=0, drain_timeout=0.
- Asserting reset_n=0 mid-DRAIN aborts immediately to IDLE, and no irq_ack is issued.

## Configuration
- **PIPE_CTRL_PERF_EN defined:**
  - perf_clr and the three counters exist.
  - perf_stall_cnt increments on cycles with any stall_req set.
  - perf_flush_cnt increments on cycles with any flush_req set.
  - perf_irq_cnt increments on each irq_ack.
  - All counters reset to 0.
- **PIPE_CTRL_PERF_EN undefined:** these ports and the counter logic are absent, and all other behaviour is identical.

## Test plan
- Reset, then all inputs 0 for 3 cycles -> stage_en=5'b11111, stage_clr=5'b00000, irq_ack=0.
- stall_req=5'b00100 (NSTAGES=5) -> stage_en=5'b11000 and stage_clr=5'b01000. Then add flush_req=5'b10000 (stall in stage 2, flush from stage 4) -> stage_en=5'b11111, stage_clr=5'b11110.
- stall_req=5'b01000 with flush_req=5'b00100 -> the stall wins: stage_en=5'b10000, stage_clr=5'b10000, no flush clears.
- irq_req pulsed for 1 cycle, no stalls, inflight_busy=0 -> DRAIN lasts 4 cycles; irq_ack is high exactly 5 cycles after the request, with drain_timeout=0.
- irq_req with inflight_busy held at 1 (DRAIN_MAX=15) -> irq_ack and drain_timeout are both high on the same cycle, 17 cycles after the request.
- reset_n dropped for 1 cycle during DRAIN -> no irq_ack, and the FSM returns to IDLE. With PIPE_CTRL_PERF_EN, perf_irq_cnt stays 0; after 2 completed interrupts it reads 2.
